// File: rtl/pairhmm_pkg.sv
// Shared definitions for the pair-HMM datapath: tag width and double-precision
// result width used by the multiplier and its downstream collector.
package pairhmm_pkg;
  localparam int TAG_W    = 4;
  localparam int DOUBLE_W = 64;
  typedef logic [TAG_W-1:0] TAG;
endpackage

// File: rtl/double_result_reorder.sv
// Collects tagged multiplier results that may finish out of order and
// releases them strictly in tag order, backpressuring the multiplier.
module double_result_reorder
  import pairhmm_pkg::*;
#(
  parameter TAG TAG_START    = TAG'(1),
  parameter int STALL_MARGIN = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DOUBLE_W-1:0] in_z,
  input  logic                in_done,
  input  TAG                  in_tag,
  output logic                global_stall,
  output logic [DOUBLE_W-1:0] out_z,
  output TAG                  out_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                dup_err
);

  localparam int DEPTH = 2 ** TAG_W;
  localparam logic [TAG_W:0] STALL_LEVEL = (TAG_W + 1)'(DEPTH - STALL_MARGIN);

  logic [DEPTH-1:0]    entry_valid;
  logic [DOUBLE_W-1:0] entry_z [DEPTH];

  TAG             next_tag;
  logic [TAG_W:0] count;
  logic [TAG_W:0] count_next;

  logic load_en;
  logic buf_hit;
  logic is_dup;
  logic fresh;
  logic bypass;
  logic buf_write;
  logic buf_read;
  logic load;

  always_comb begin
    load_en    = !out_valid || out_ready;
    buf_hit    = entry_valid[next_tag];
    // A tag sitting in the output register counts as already held.
    is_dup     = in_done && (entry_valid[in_tag] || (out_valid && (out_tag == in_tag)));
    fresh      = in_done && !is_dup;
    bypass     = load_en && !buf_hit && fresh && (in_tag == next_tag);
    buf_write  = fresh && !bypass;
    buf_read   = load_en && buf_hit;
    load       = buf_read || bypass;
    count_next = count + {{TAG_W{1'b0}}, buf_write} - {{TAG_W{1'b0}}, buf_read};
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_valid[gi] <= 1'b0;
        end else if (buf_write && (in_tag == TAG'(gi))) begin
          entry_valid[gi] <= 1'b1;
        end else if (buf_read && (next_tag == TAG'(gi))) begin
          entry_valid[gi] <= 1'b0;
        end
      end

      // Payload needs no reset; the valid bit alone decides ownership.
      always_ff @(posedge clk) begin
        if (buf_write && (in_tag == TAG'(gi))) begin
          entry_z[gi] <= in_z;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_z        <= '0;
      out_tag      <= '0;
      next_tag     <= TAG_START;
      count        <= '0;
      global_stall <= 1'b0;
      dup_err      <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_z     <= buf_hit ? entry_z[next_tag] : in_z;
        out_tag   <= next_tag;
        next_tag  <= next_tag + TAG'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      count        <= count_next;
      global_stall <= (count_next >= STALL_LEVEL);
      dup_err      <= dup_err || is_dup;
    end
  end

endmodule

// File: tb/tb_double_result_reorder.sv
// Directed self-checking bench for the in-order result collector.
module tb_double_result_reorder;
  import pairhmm_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [DOUBLE_W-1:0] in_z;
  logic                in_done;
  TAG                  in_tag;
  logic                global_stall;
  logic [DOUBLE_W-1:0] out_z;
  TAG                  out_tag;
  logic                out_valid;
  logic                out_ready;
  logic                dup_err;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D1 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D2 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D3 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D4 = 64'h4010_0000_0000_0000;

  double_result_reorder dut (
    .clk(clk), .reset(reset), .in_z(in_z), .in_done(in_done), .in_tag(in_tag),
    .global_stall(global_stall), .out_z(out_z), .out_tag(out_tag),
    .out_valid(out_valid), .out_ready(out_ready), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input TAG t, input logic [63:0] z);
    in_done = 1'b1;
    in_tag  = t;
    in_z    = z;
  endtask

  task automatic idle();
    in_done = 1'b0;
    in_tag  = '0;
    in_z    = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_z"}, out_z, 64'd0);
    check({pfx, "_tag"}, 64'(out_tag), 64'd0);
    check({pfx, "_stall"}, 64'(global_stall), 64'd0);
    check({pfx, "_dup"}, 64'(dup_err), 64'd0);
  endtask

  task automatic expect_out(input string name, input TAG t, input logic [63:0] z);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_tag"}, 64'(out_tag), 64'(t));
    check({name, "_z"}, out_z, z);
    $display("out tag=%0d z=%h", out_tag, out_z);
  endtask

  initial begin
    in_done = 1'b0; in_tag = '0; in_z = '0; out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_state("rst0");
    @(negedge clk);
    reset = 1'b1;

    // In-order stream: each result appears one cycle after arrival.
    out_ready = 1'b1;
    @(negedge clk);
    send(TAG'(1), D2); step(); expect_out("io1", TAG'(1), D2);
    send(TAG'(2), D3); step(); expect_out("io2", TAG'(2), D3);
    send(TAG'(3), D4); step(); expect_out("io3", TAG'(3), D4);
    idle(); step();
    check("io_empty", 64'(out_valid), 64'd0);
    check("io_stall", 64'(global_stall), 64'd0);

    // Out of order: 3,2,1 in, 1,2,3 out.
    pulse_reset();
    out_ready = 1'b1;
    send(TAG'(3), D3); step(); check("ooo_wait3", 64'(out_valid), 64'd0);
    send(TAG'(2), D2); step(); check("ooo_wait2", 64'(out_valid), 64'd0);
    send(TAG'(1), D1); step(); expect_out("ooo1", TAG'(1), D1);
    idle();            step(); expect_out("ooo2", TAG'(2), D2);
                       step(); expect_out("ooo3", TAG'(3), D3);
                       step(); check("ooo_empty", 64'(out_valid), 64'd0);

    // Backpressure: tags 2..11 buffered while tag 1 is missing.
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      send(TAG'(i), 64'hB000_0000_0000_0000 | 64'(i));
      step();
    end
    check("bp_stall9", 64'(global_stall), 64'd0);
    send(TAG'(11), 64'hB000_0000_0000_000B);
    step();
    check("bp_stall10", 64'(global_stall), 64'd1);
    check("bp_novalid", 64'(out_valid), 64'd0);
    send(TAG'(1), 64'hB000_0000_0000_0001);
    out_ready = 1'b1;
    step();
    expect_out("bp1", TAG'(1), 64'hB000_0000_0000_0001);
    check("bp_stall_hold", 64'(global_stall), 64'd1);
    idle();
    step();
    expect_out("bp2", TAG'(2), 64'hB000_0000_0000_0002);
    check("bp_stall_drop", 64'(global_stall), 64'd0);
    for (int i = 3; i <= 11; i++) begin
      step();
      expect_out($sformatf("bp%0d", i), TAG'(i), 64'hB000_0000_0000_0000 | 64'(i));
    end
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Wrap-around: 20 in-order results from tag 1.
    pulse_reset();
    out_ready = 1'b1;
    begin
      TAG exp_tags [20] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0,1,2,3,4};
      for (int i = 0; i < 20; i++) begin
        send(exp_tags[i], 64'hA000_0000_0000_0000 | 64'(i));
        step();
        expect_out($sformatf("wrap%0d", i), exp_tags[i], 64'hA000_0000_0000_0000 | 64'(i));
      end
    end
    idle(); step();
    check("wrap_empty", 64'(out_valid), 64'd0);

    // Duplicate tag 5 while buffered.
    pulse_reset();
    out_ready = 1'b0;
    send(TAG'(1), 64'hD1); step(); expect_out("dup_o1", TAG'(1), 64'hD1);
    send(TAG'(5), 64'hAAAA); step(); check("dup_before", 64'(dup_err), 64'd0);
    send(TAG'(5), 64'hBBBB); step(); check("dup_set", 64'(dup_err), 64'd1);
    send(TAG'(2), 64'hD2); step();
    send(TAG'(3), 64'hD3); step();
    send(TAG'(4), 64'hD4); step();
    idle();
    check("dup_hold_tag", 64'(out_tag), 64'd1);
    check("dup_hold_z", out_z, 64'hD1);
    out_ready = 1'b1;
    step(); expect_out("dup_o2", TAG'(2), 64'hD2);
    step(); expect_out("dup_o3", TAG'(3), 64'hD3);
    step(); expect_out("dup_o4", TAG'(4), 64'hD4);
    step(); expect_out("dup_o5", TAG'(5), 64'hAAAA);
    step();
    check("dup_single5", 64'(out_valid), 64'd0);
    check("dup_sticky", 64'(dup_err), 64'd1);

    // Reset mid-operation with output held and 4 entries buffered.
    out_ready = 1'b0;
    pulse_reset();
    send(TAG'(1), 64'hE1); step();
    send(TAG'(2), 64'hE2); step();
    send(TAG'(3), 64'hE3); step();
    send(TAG'(4), 64'hE4); step();
    send(TAG'(5), 64'hE5); step();
    idle();
    expect_out("mid_pre", TAG'(1), 64'hE1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    send(TAG'(1), 64'hF1); step(); expect_out("mid_post", TAG'(1), 64'hF1);
    idle(); step();
    check("mid_cleared", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/double_result_reorder.md
# double_result_reorder

Downstream collector for `double_multiply_pipe`. It accepts tagged double-precision results, which may complete out of issue order, and holds them in a tag-indexed buffer. It releases them strictly in tag order through a valid/ready output, and drives the multiplier's `global_stall` so that in-flight results can never overflow the buffer.

## Interface
Parameters:
- `TAG_START`, default 1: first tag expected after reset; matches the issuer's initial tag.
- `STALL_MARGIN`, default 6: free entries reserved for results already in flight in the upstream pipe.
- `DEPTH`, derived as `2**TAG_W` = 16: buffer entries, one per tag value. Not overridable.

Ports (all synchronous to `clk`; `reset` is asynchronous and active-low):
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: active-low, asynchronous assert, synchronous deassert at the system level.
- `in_z` input 64: IEEE-754 double result from the multiplier.
- `in_done` input 1: `in_z`/`in_tag` valid this cycle.
- `in_tag` input TAG (4): tag of the incoming result.
- `global_stall` output 1: backpressure to the multiplier; registered-derived.
- `out_z` output 64: in-order result.
- `out_tag` output TAG: tag of `out_z`.
- `out_valid` output 1: output register holds a result.
- `out_ready` input 1: consumer accepts; a transfer occurs when `out_valid & out_ready` at the clock edge.
- `dup_err` output 1: sticky flag, set when a result arrives for a tag that is already buffered.

## Operation
Buffer:
- 16 entries of `{valid, z}`, indexed directly by tag.
- `next_tag` register is the tag of the next result to release. It increments mod 16 on every load of the output register; 15 wraps to 0.
- `count` register holds the number of valid buffer entries, 0..16. The output register is not counted.

Write path, when `in_done`:
- If `entry[in_tag].valid`, or the output register currently holds `in_tag`: drop the result, set `dup_err`, and leave the buffer unchanged.
- Else if the bypass condition holds (below): the result goes directly to the output register and is not written to the buffer.
- Else: write the entry and set it valid.

Output register load occurs when the register is empty, or is being drained this cycle (`out_valid & out_ready`). Source priority:
1. `entry[next_tag].valid`: load from the buffer and clear that entry.
2. Bypass: `in_done & in_tag == next_tag` with a fresh tag.

A load sets `out_valid`, sets `out_tag = next_tag`, and increments `next_tag`.

Count update:
- Net change per cycle = (buffer write ? +1 : 0) − (buffer read ? 1 : 0).
- A simultaneous write and read leaves `count` unchanged.

`global_stall` = `count >= DEPTH - STALL_MARGIN`, i.e. asserted at `count >= 10`.

Holding rule: while `out_valid & !out_ready`, `out_z` and `out_tag` must stay stable.

## Timing
Reset values:
- `out_valid` = 0, `out_z` = 0, `out_tag` = 0.
- `global_stall` = 0, `dup_err` = 0.
- `next_tag` = `TAG_START`, `count` = 0.
- All entry valid bits = 0.

Latency:
- An in-order result with the output register empty or draining: `in_done` at edge N gives `out_valid` after edge N (1 cycle, via bypass).
- A buffered result: it appears on the edge after its predecessor is consumed.

Throughput: one result per cycle in and out when `out_ready` is held high.

Stall:
- `global_stall` updates the cycle after `count` crosses 10.
- The upstream pipe must tolerate one further accepted issue after assertion. `STALL_MARGIN` covers this.

Boundary conditions:
- Full (`count == 16`): any further `in_done` is necessarily a duplicate and is dropped with `dup_err` set.
- Empty: `out_valid` drops after the final transfer.
- `dup_err` clears only on reset.
- Reset mid-operation: all buffered and output data is discarded immediately (asynchronously), and `next_tag` returns to `TAG_START`.

## Structure
- The shared package `pairhmm_pkg` holds `TAG_W` = 4, `typedef logic [TAG_W-1:0] TAG`, and `DOUBLE_W` = 64. The multiplier and this block both import it.
- Single module, no sub-module. Storage is a flop array, because 16×65 bits is small and each entry needs individual valid clearing.

## Test plan
- **In-order stream:** tags 1,2,3 with z = 2.0, 3.0, 4.0 on consecutive cycles, `out_ready` = 1 → each output appears 1 cycle later, tags 1,2,3, `count` stays 0.
- **Out of order:** tags 3,2,1 (z = 3.0, 2.0, 1.0), `out_ready` = 1 → `count` reaches 2, then the outputs emerge as tags 1,2,3 on consecutive cycles, with tag 1 following the cycle of its arrival.
- **Backpressure:** `out_ready` = 0 and 10 results written for tags 2..11 while tag 1 is missing → `global_stall` = 1 the cycle after the 10th write. Then send tag 1 and raise `out_ready` → 11 in-order outputs, and `global_stall` deasserts once `count` < 10.
- **Wrap-around:** 20 in-order results starting at tag 1 → `out_tag` sequence 1..15, 0, 1..4, with no gaps.
- **Duplicate:** tag 5 twice while it is buffered → the second copy is dropped, `dup_err` = 1 and stays high, only one output carries tag 5.
- **Reset mid-operation:** 4 entries buffered plus `out_valid` = 1, then `reset` low for 1 cycle → all outputs are at reset values immediately, and the next tag-1 input is output normally.
